// File: rtl/seg7_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared constants for the 4-digit scanned 7-segment driver: segment codes
//   ({g,f,e,d,c,b,a}, active-high), slot indices, the captured-value record and
//   a slot-to-anode helper.
// -----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, logical (1 = segment lit)
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Display slots, scanned in this order; slot index == anode bit
    localparam logic [1:0] SLOT_ONES = 2'd0;
    localparam logic [1:0] SLOT_TENS = 2'd1;
    localparam logic [1:0] SLOT_HUND = 2'd2;
    localparam logic [1:0] SLOT_SIGN = 2'd3;

    // Signed BCD value as captured from the converter
    typedef struct packed {
        logic       sign;
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_value_t;

    // Logical (active-high) anode pattern for a slot
    function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
        return 4'b0001 << slot;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational BCD to 7-segment decoder. Digits 0..9 map to their glyph,
//   codes 10..15 show 'E' so a corrupt converter result is visible on the board.
// Ports
//   i_digit  in   4  BCD digit
//   o_seg    out  7  {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // o_seg unassigned, which would otherwise infer a latch.
        o_seg = SEG_E;
        case (i_digit)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Captures the signed BCD result of the binary-to-BCD converter on the rising
//   edge of data_ready and scans it onto a 4-digit multiplexed 7-segment
//   display laid out [sign][H][T][O]. Leading zeros are blanked, each digit slot
//   lasts REFRESH_DIV clocks and starts with BLANK_CYCLES of all anodes off to
//   suppress ghosting. All outputs are registered.
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  anode-off cycles at slot start (0 .. REFRESH_DIV-1)
//   ACTIVE_LOW    1: seg/an inverted for a common-anode board
// Ports
//   clk         in   1  clock, all logic on posedge
//   rst         in   1  synchronous reset, active-low
//   sign        in   1  1 = negative
//   hundreds    in   4  BCD hundreds
//   tens        in   4  BCD tens
//   ones        in   4  BCD ones
//   data_ready  in   1  level, inputs valid while high
//   seg         out  7  {g,f,e,d,c,b,a}
//   an          out  4  an[0]=ones .. an[3]=sign
//   new_value   out  1  one-cycle pulse the cycle after a capture
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sign,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       data_ready,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       new_value
);

    localparam int              PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   BLANK_LIM  = PW'(BLANK_CYCLES);
    // XOR masks applying output polarity; they are also the "all off" values
    localparam logic [6:0]      SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]      AN_OFF     = (ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

    bcd_value_t    r_value;
    logic          r_dr_d;
    logic          r_new_value;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_slot;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_capture;
    logic          w_gap;
    logic [3:0]    w_dec_digit;
    logic [6:0]    w_dec_seg;
    logic [6:0]    w_slot_seg;

    // Only a low-to-high transition captures; holding data_ready high never
    // recaptures, so the display cannot change under a held level.
    assign w_capture = data_ready & ~r_dr_d;
    assign w_gap     = (r_presc < BLANK_LIM);

    // ---------------- capture ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value     <= '0;
            r_dr_d      <= 1'b0;
            r_new_value <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // pre-edge values (r_dr_d feeds w_capture in this same edge).
            r_dr_d      <= data_ready;
            r_new_value <= w_capture;
            if (w_capture) begin
                r_value <= {sign, hundreds, tens, ones};
            end
        end
    end

    // ---------------- prescaler and slot counter ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_slot  <= SLOT_ONES;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_slot  <= r_slot + 2'd1;   // natural 2-bit wrap 3 -> 0
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // ---------------- slot content (logical polarity) ----------------
    seg7_decode u_decode (
        .i_digit (w_dec_digit),
        .o_seg   (w_dec_seg)
    );

    // Leading-zero blanking looks at the digit value, so an invalid (>9)
    // hundreds/tens is non-zero, never blanked, and decodes to 'E'.
    always_comb begin
        w_dec_digit = r_value.ones;
        w_slot_seg  = w_dec_seg;
        case (r_slot)
            SLOT_ONES: begin
                w_dec_digit = r_value.ones;
                w_slot_seg  = w_dec_seg;
            end
            SLOT_TENS: begin
                w_dec_digit = r_value.tens;
                w_slot_seg  = (r_value.hund == 4'd0 && r_value.tens == 4'd0)
                              ? SEG_BLANK : w_dec_seg;
            end
            SLOT_HUND: begin
                w_dec_digit = r_value.hund;
                w_slot_seg  = (r_value.hund == 4'd0) ? SEG_BLANK : w_dec_seg;
            end
            SLOT_SIGN: begin
                w_slot_seg  = r_value.sign ? SEG_DASH : SEG_BLANK;
            end
            default: begin
                w_slot_seg  = SEG_BLANK;
            end
        endcase
    end

    // ---------------- output registers ----------------
    // Segments carry slot content for the whole slot; only the anodes blank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_slot_seg ^ SEG_OFF;
            r_an  <= (w_gap ? 4'b0000 : slot_onehot(r_slot)) ^ AN_OFF;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign new_value = r_new_value;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Two instances (active-high and active-low outputs) share stimulus. The
//   stimulus process pushes the expected glyph for each digit slot into a
//   queue; a monitor pops one entry every time a slot lights up (anodes go
//   from all-off to one-hot) and compares both instances. The monitor also
//   checks the anti-ghosting gap length and the new_value pulse shape.
//   REFRESH_DIV=4, BLANK_CYCLES=1: a full scan takes 16 cycles.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } pres_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       data_ready = 1'b0;

    logic [6:0] seg, seg_al;
    logic [3:0] an, an_al;
    logic       new_value, new_value_al;

    pres_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    nv_count = 0;
    int    exp_nv   = 0;
    int    done_cyc = 0;   // posedges taken with rst high since last reset

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .sign(sign), .hundreds(hundreds), .tens(tens),
        .ones(ones), .data_ready(data_ready), .seg(seg), .an(an),
        .new_value(new_value)
    );

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .sign(sign), .hundreds(hundreds), .tens(tens),
        .ones(ones), .data_ready(data_ready), .seg(seg_al), .an(an_al),
        .new_value(new_value_al)
    );

    always #5 clk = ~clk;

    always @(posedge clk) done_cyc <= rst ? done_cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [3:0] prev_an;
        logic       prev_nv;
        int         gap;
        bit         seen_lit;
        pres_t      e;
        prev_an  = 4'd0;
        prev_nv  = 1'b0;
        gap      = 0;
        seen_lit = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_an  = 4'd0;
                prev_nv  = 1'b0;
                gap      = 0;
                seen_lit = 1'b0;
            end else begin
                if (new_value === 1'b1) begin
                    nv_count++;
                    check("new_value single-cycle", {31'd0, prev_nv}, 32'd0);
                    check("new_value active-low twin", {31'd0, new_value_al}, 32'd1);
                end
                if (an === 4'b0000) begin
                    gap++;
                end else if (prev_an === 4'b0000) begin
                    if (seen_lit) check("blank gap cycles", gap, 1);
                    seen_lit = 1'b1;
                    gap      = 0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("scan an", {28'd0, an}, {28'd0, e.an});
                        check("scan seg", {25'd0, seg}, {25'd0, e.seg});
                        check("scan an active-low", {28'd0, an_al}, {28'd0, e.an ^ 4'hF});
                        check("scan seg active-low", {25'd0, seg_al}, {25'd0, e.seg ^ 7'h7F});
                    end
                end
                prev_an = an;
                prev_nv = new_value;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_scan(input logic [6:0] s_ones, input logic [6:0] s_tens,
                             input logic [6:0] s_hund, input logic [6:0] s_sign);
        exp_q.push_back('{an: 4'b0001, seg: s_ones});
        exp_q.push_back('{an: 4'b0010, seg: s_tens});
        exp_q.push_back('{an: 4'b0100, seg: s_hund});
        exp_q.push_back('{an: 4'b1000, seg: s_sign});
    endtask

    // Return at a negedge where the next posedge starts a new slot-0 period
    task automatic sync_slot0();
        do @(negedge clk); while (done_cyc % 16 != 0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        check({tag, " scan entries left"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, " new_value count"}, nv_count, exp_nv);
    endtask

    task automatic capture(input logic s, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o);
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        sign = s; hundreds = h; tens = t; ones = o;
        data_ready = 1'b1;
        exp_nv++;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        // 1: reset state, then zero value shows '0' in the ones slot only
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset seg", {25'd0, seg}, 32'h00);
        check("reset an", {28'd0, an}, 32'h0);
        check("reset new_value", {31'd0, new_value}, 32'd0);
        check("reset seg active-low", {25'd0, seg_al}, 32'h7F);
        check("reset an active-low", {28'd0, an_al}, 32'hF);
        push_scan(7'h3F, 7'h00, 7'h00, 7'h00);
        rst = 1'b1;
        drain("s1");

        // 2: -123
        capture(1'b1, 4'd1, 4'd2, 4'd3);
        sync_slot0();
        push_scan(7'h4F, 7'h5B, 7'h06, 7'h40);
        drain("s2");

        // 3: +5, leading zeros blanked
        capture(1'b0, 4'd0, 4'd0, 4'd5);
        sync_slot0();
        push_scan(7'h6D, 7'h00, 7'h00, 7'h00);
        drain("s3");

        // 4: inputs change under a held data_ready: no recapture
        @(negedge clk);
        hundreds = 4'd9;
        sync_slot0();
        push_scan(7'h6D, 7'h00, 7'h00, 7'h00);
        drain("s4 held");
        capture(1'b0, 4'd9, 4'd0, 4'd5);
        sync_slot0();
        push_scan(7'h6D, 7'h3F, 7'h6F, 7'h00);
        drain("s4 recapture");

        // 5: invalid tens shows 'E', zero hundreds blanked
        capture(1'b0, 4'd0, 4'hA, 4'd0);
        sync_slot0();
        push_scan(7'h3F, 7'h79, 7'h00, 7'h00);
        drain("s5");

        // invalid hundreds is never blanked
        capture(1'b1, 4'hC, 4'd0, 4'd7);
        sync_slot0();
        push_scan(7'h07, 7'h3F, 7'h79, 7'h40);
        drain("s5 bad hundreds");

        // 6: reset in the middle of slot 2
        do @(negedge clk); while (done_cyc % 16 != 10);
        check("slot 2 lit before reset", {28'd0, an}, 32'h4);
        rst = 1'b0;
        @(negedge clk);
        check("mid-scan reset an", {28'd0, an}, 32'h0);
        check("mid-scan reset seg", {25'd0, seg}, 32'h00);
        check("mid-scan reset new_value", {31'd0, new_value}, 32'd0);
        check("mid-scan reset an active-low", {28'd0, an_al}, 32'hF);
        check("mid-scan reset seg active-low", {25'd0, seg_al}, 32'h7F);
        // data_ready high at release is a rising edge against the cleared history
        sign = 1'b1; hundreds = 4'd1; tens = 4'd2; ones = 4'd3;
        data_ready = 1'b1;
        exp_nv++;
        push_scan(7'h4F, 7'h5B, 7'h06, 7'h40);
        @(negedge clk);
        rst = 1'b1;
        drain("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
